// File: rtl/disp_sched_pkg.sv
// disp_sched_pkg: shared constants and types for the display scheduler.
//   - Digit codes understood by seven_seg (OFF, NEG; 0-9 pass through).
//   - Source encodings reported on disp_sched.src.
//   - Scheduler state encoding.
//   - sign_code(): maps a sign flag to the leading-digit code.
package disp_sched_pkg;

    localparam logic [3:0] DIG_OFF = 4'hF;
    localparam logic [3:0] DIG_NEG = 4'hA;

    localparam logic [1:0] SRC_ENTRY = 2'd0;
    localparam logic [1:0] SRC_TEMP  = 2'd1;
    localparam logic [1:0] SRC_DELTA = 2'd2;
    localparam logic [1:0] SRC_BLANK = 2'd3;

    typedef enum logic [2:0] {
        StEntry,
        StShowTemp,
        StBlankA,
        StShowDelta,
        StBlankB
    } state_t;

    function automatic logic [3:0] sign_code(input logic neg);
        return neg ? DIG_NEG : DIG_OFF;
    endfunction

endpackage

// File: rtl/disp_dwell_timer.sv
// disp_dwell_timer: tick counter with synchronous clear and variable limit.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset (wins over tick)
//   tick   in  time-base pulse; counted when not cleared
//   clr    in  clear counter to zero at the next edge
//   limit  in  number of ticks in the current dwell (1..2^CNT_W-1)
//   expire out tick arriving on the last count of the dwell
module disp_dwell_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire = tick && (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/disp_sched.sv
// disp_sched: sequencer/arbiter for the shared four-digit seven-segment display.
// Live entry preempts; otherwise rotates temp -> blank -> delta -> blank on a
// tick-based dwell timer. All outputs are registered.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tick              time base for dwell and blink
//   entry_active/pos/sign/bcd   live BCD entry (pos 3 behaves as 2)
//   temp_bcd/temp_neg           current temperature
//   delta_bcd/delta_neg/delta_valid   subtractor result
//   seg_val           {d3,d2,d1,d0} digit codes
//   seg_en            per-digit enable
//   src               0=entry 1=temp 2=delta 3=blank
//   frame_done        one-clk pulse on the first temp cycle after a rotation
module disp_sched
    import disp_sched_pkg::*;
#(
    parameter int unsigned DWELL_TICKS = 2,
    parameter int unsigned GAP_TICKS   = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        entry_active,
    input  logic [1:0]  entry_pos,
    input  logic        entry_sign,
    input  logic [11:0] entry_bcd,
    input  logic [11:0] temp_bcd,
    input  logic        temp_neg,
    input  logic [11:0] delta_bcd,
    input  logic        delta_neg,
    input  logic        delta_valid,
    output logic [15:0] seg_val,
    output logic [3:0]  seg_en,
    output logic [1:0]  src,
    output logic        frame_done
);

    state_t      state_q, state_d;
    logic        blink_q, blink_d;
    logic [1:0]  pos_q, pos_eff;
    logic        frame_done_d;
    logic [15:0] seg_val_d;
    logic [3:0]  seg_en_d;
    logic [1:0]  src_d;
    logic        expire;
    logic        clr;
    logic [CNT_W-1:0] limit;

    assign pos_eff = (entry_pos == 2'd3) ? 2'd2 : entry_pos;

    assign limit = (state_q == StShowTemp || state_q == StShowDelta) ?
                   CNT_W'(DWELL_TICKS) : CNT_W'(GAP_TICKS);

    // Counter restarts on every state change so each state sees a full dwell.
    assign clr = (state_d != state_q);

    disp_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clr    (clr),
        .limit  (limit),
        .expire (expire)
    );

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        if (state_q != StEntry && entry_active) begin
            // Entry wins even over an expiry in the same cycle.
            state_d = StEntry;
        end else begin
            case (state_q)
                StEntry: begin
                    if (!entry_active) state_d = StShowTemp;
                end
                StShowTemp: begin
                    if (expire) state_d = StBlankA;
                end
                StBlankA: begin
                    if (expire) begin
                        if (delta_valid) begin
                            state_d = StShowDelta;
                        end else begin
                            state_d      = StShowTemp;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                StShowDelta: begin
                    if (!delta_valid || expire) state_d = StBlankB;
                end
                StBlankB: begin
                    if (expire) begin
                        state_d      = StShowTemp;
                        frame_done_d = 1'b1;
                    end
                end
                default: state_d = StShowTemp;
            endcase
        end
    end

    // Blink: forced on when entering ENTRY or moving the cursor; the force
    // takes precedence over a same-cycle tick.
    always_comb begin
        blink_d = blink_q;
        if (state_d == StEntry) begin
            if (state_q != StEntry || pos_eff != pos_q) begin
                blink_d = 1'b1;
            end else if (tick) begin
                blink_d = ~blink_q;
            end
        end
    end

    // Output mux, driven from the next state so outputs track inputs with
    // one clock of latency.
    always_comb begin
        seg_val_d = {4{DIG_OFF}};
        seg_en_d  = 4'hF;
        src_d     = SRC_BLANK;
        case (state_d)
            StEntry: begin
                seg_val_d[15:12] = sign_code(entry_sign);
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) <= pos_eff) begin
                        seg_val_d[4*i +: 4] = entry_bcd[4*i +: 4];
                    end
                end
                seg_en_d[pos_eff] = blink_d;
                src_d             = SRC_ENTRY;
            end
            StShowTemp: begin
                seg_val_d = {sign_code(temp_neg), temp_bcd};
                src_d     = SRC_TEMP;
            end
            StShowDelta: begin
                seg_val_d = {sign_code(delta_neg), delta_bcd};
                src_d     = SRC_DELTA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StShowTemp;
            blink_q    <= 1'b1;
            pos_q      <= 2'd0;
            seg_val    <= {4{DIG_OFF}};
            seg_en     <= 4'hF;
            src        <= SRC_TEMP;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            blink_q    <= blink_d;
            pos_q      <= pos_eff;
            seg_val    <= seg_val_d;
            seg_en     <= seg_en_d;
            src        <= src_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched: scenario tasks for disp_sched. Each cycle's stimulus row
// carries its expected registered outputs, which are pushed to a scoreboard
// queue when driven and popped for comparison after the next clock edge.
module tb_disp_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        entry_active;
    logic [1:0]  entry_pos;
    logic        entry_sign;
    logic [11:0] entry_bcd;
    logic [11:0] temp_bcd;
    logic        temp_neg;
    logic [11:0] delta_bcd;
    logic        delta_neg;
    logic        delta_valid;
    logic [15:0] seg_val;
    logic [3:0]  seg_en;
    logic [1:0]  src;
    logic        frame_done;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        rst;
        logic        tick;
        logic        ea;
        logic [1:0]  pos;
        logic        sign;
        logic [11:0] ebcd;
        logic        dv;
        logic [15:0] val;
        logic [3:0]  en;
        logic [1:0]  src;
        logic        fd;
    } vec_t;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  en;
        logic [1:0]  src;
        logic        fd;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    disp_sched #(
        .DWELL_TICKS (2),
        .GAP_TICKS   (1),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .entry_active (entry_active),
        .entry_pos    (entry_pos),
        .entry_sign   (entry_sign),
        .entry_bcd    (entry_bcd),
        .temp_bcd     (temp_bcd),
        .temp_neg     (temp_neg),
        .delta_bcd    (delta_bcd),
        .delta_neg    (delta_neg),
        .delta_valid  (delta_valid),
        .seg_val      (seg_val),
        .seg_en       (seg_en),
        .src          (src),
        .frame_done   (frame_done)
    );

    function automatic vec_t mk(input logic r, input logic t, input logic ea,
                                input logic [1:0] pos, input logic sign,
                                input logic [11:0] ebcd, input logic dv,
                                input logic [15:0] val, input logic [3:0] en,
                                input logic [1:0] s, input logic fd);
        vec_t v;
        v = '{rst: r, tick: t, ea: ea, pos: pos, sign: sign, ebcd: ebcd, dv: dv,
              val: val, en: en, src: s, fd: fd};
        return v;
    endfunction

    // Drive one row of stimulus and queue the outputs it should produce.
    task automatic drive(input vec_t v);
        rst          = v.rst;
        tick         = v.tick;
        entry_active = v.ea;
        entry_pos    = v.pos;
        entry_sign   = v.sign;
        entry_bcd    = v.ebcd;
        delta_valid  = v.dv;
        exp_q.push_back('{val: v.val, en: v.en, src: v.src, fd: v.fd});
    endtask

    task automatic test_reset();
        vec_t v[$];
        exp_t e;
        // tick during reset is ignored
        v.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, 16'hFFFF, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 12'h000, 0, 16'hF072, 4'hF, 2'd1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_val, seg_en, src, frame_done} !== {e.val, e.en, e.src, e.fd}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got val=%h en=%b src=%0d fd=%b, want val=%h en=%b src=%0d fd=%b",
                         i, seg_val, seg_en, src, frame_done, e.val, e.en, e.src, e.fd);
            end
        end
    endtask

    task automatic test_rotate_temp();
        vec_t v[$];
        exp_t e;
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 0, 16'hF072, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 12'h000, 0, 16'hF072, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 0, 16'hFFFF, 4'hF, 2'd3, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 12'h000, 0, 16'hFFFF, 4'hF, 2'd3, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 0, 16'hF072, 4'hF, 2'd1, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 12'h000, 0, 16'hF072, 4'hF, 2'd1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_val, seg_en, src, frame_done} !== {e.val, e.en, e.src, e.fd}) begin
                n_bad++;
                $display("FAIL rotate_temp[%0d]: got val=%h en=%b src=%0d fd=%b, want val=%h en=%b src=%0d fd=%b",
                         i, seg_val, seg_en, src, frame_done, e.val, e.en, e.src, e.fd);
            end
        end
    endtask

    task automatic test_rotate_delta();
        vec_t v[$];
        exp_t e;
        // back-to-back ticks through the full four-phase rotation
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hF072, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hFFFF, 4'hF, 2'd3, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hA015, 4'hF, 2'd2, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 12'h000, 1, 16'hA015, 4'hF, 2'd2, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hA015, 4'hF, 2'd2, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hFFFF, 4'hF, 2'd3, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hF072, 4'hF, 2'd1, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 12'h000, 1, 16'hF072, 4'hF, 2'd1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_val, seg_en, src, frame_done} !== {e.val, e.en, e.src, e.fd}) begin
                n_bad++;
                $display("FAIL rotate_delta[%0d]: got val=%h en=%b src=%0d fd=%b, want val=%h en=%b src=%0d fd=%b",
                         i, seg_val, seg_en, src, frame_done, e.val, e.en, e.src, e.fd);
            end
        end
    endtask

    task automatic test_entry_blink();
        vec_t v[$];
        exp_t e;
        // reach SHOW_DELTA on its last dwell tick
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hF072, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hFFFF, 4'hF, 2'd3, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hA015, 4'hF, 2'd2, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hA015, 4'hF, 2'd2, 0));
        // entry preempts a same-cycle expiry
        v.push_back(mk(0, 1, 1, 1, 1, 12'h034, 1, 16'hAF34, 4'hF, 2'd0, 0));
        v.push_back(mk(0, 1, 1, 1, 1, 12'h034, 1, 16'hAF34, 4'hD, 2'd0, 0));
        v.push_back(mk(0, 0, 1, 1, 1, 12'h034, 1, 16'hAF34, 4'hD, 2'd0, 0));
        v.push_back(mk(0, 1, 1, 1, 1, 12'h034, 1, 16'hAF34, 4'hF, 2'd0, 0));
        // cursor move with a tick: force keeps blink on
        v.push_back(mk(0, 1, 1, 2, 1, 12'h034, 1, 16'hA034, 4'hF, 2'd0, 0));
        v.push_back(mk(0, 1, 1, 2, 1, 12'h034, 1, 16'hA034, 4'hB, 2'd0, 0));
        // release: back to temp, fresh dwell, no frame_done
        v.push_back(mk(0, 0, 0, 2, 1, 12'h034, 1, 16'hF072, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 1, 0, 2, 1, 12'h034, 1, 16'hF072, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 1, 0, 2, 1, 12'h034, 1, 16'hFFFF, 4'hF, 2'd3, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_val, seg_en, src, frame_done} !== {e.val, e.en, e.src, e.fd}) begin
                n_bad++;
                $display("FAIL entry_blink[%0d]: got val=%h en=%b src=%0d fd=%b, want val=%h en=%b src=%0d fd=%b",
                         i, seg_val, seg_en, src, frame_done, e.val, e.en, e.src, e.fd);
            end
        end
    endtask

    task automatic test_delta_drop();
        vec_t v[$];
        exp_t e;
        // from BLANK_A into SHOW_DELTA, then drop delta_valid at cnt=0
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 1, 16'hA015, 4'hF, 2'd2, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 12'h000, 0, 16'hFFFF, 4'hF, 2'd3, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h000, 0, 16'hF072, 4'hF, 2'd1, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 12'h000, 0, 16'hF072, 4'hF, 2'd1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_val, seg_en, src, frame_done} !== {e.val, e.en, e.src, e.fd}) begin
                n_bad++;
                $display("FAIL delta_drop[%0d]: got val=%h en=%b src=%0d fd=%b, want val=%h en=%b src=%0d fd=%b",
                         i, seg_val, seg_en, src, frame_done, e.val, e.en, e.src, e.fd);
            end
        end
    endtask

    task automatic test_reset_in_entry();
        vec_t v[$];
        exp_t e;
        // entry at the ones digit, positive sign
        v.push_back(mk(0, 0, 1, 0, 0, 12'h034, 0, 16'hFFF4, 4'hF, 2'd0, 0));
        v.push_back(mk(1, 1, 1, 0, 0, 12'h034, 0, 16'hFFFF, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 12'h034, 0, 16'hF072, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h034, 0, 16'hF072, 4'hF, 2'd1, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 12'h034, 0, 16'hFFFF, 4'hF, 2'd3, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_val, seg_en, src, frame_done} !== {e.val, e.en, e.src, e.fd}) begin
                n_bad++;
                $display("FAIL reset_in_entry[%0d]: got val=%h en=%b src=%0d fd=%b, want val=%h en=%b src=%0d fd=%b",
                         i, seg_val, seg_en, src, frame_done, e.val, e.en, e.src, e.fd);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        tick         = 1'b0;
        entry_active = 1'b0;
        entry_pos    = 2'd0;
        entry_sign   = 1'b0;
        entry_bcd    = 12'h000;
        temp_bcd     = 12'h072;
        temp_neg     = 1'b0;
        delta_bcd    = 12'h015;
        delta_neg    = 1'b1;
        delta_valid  = 1'b0;
        test_reset();
        test_rotate_temp();
        test_rotate_delta();
        test_entry_blink();
        test_delta_drop();
        test_reset_in_entry();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got still running, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
- Sequencer/arbiter for the shared four-digit seven-segment display.
- Three requesters share the display: live BCD entry, current temperature and temperature delta (subtractor result).
- Entry always preempts. Otherwise the block rotates temperature, blank gap, delta and blank gap on a tick-based dwell timer.
- Sits between the bcd_in / subtractor datapath and the four seven_seg instances, replacing ad-hoc display muxing.

Parameters:
- DWELL_TICKS, 2, ticks each source (temp/delta) is shown; legal range 1..2^CNT_W-1
- GAP_TICKS, 1, ticks of all-blank display between sources; legal range 1..2^CNT_W-1
- CNT_W, 4, width of the tick counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-clk pulse from the clock divider; time base for dwell and blink
- entry_active  in  1  user is entering a digit
- entry_pos  in  2  digit being edited: 0=ones, 1=tens, 2=huns; 3 is treated as 2
- entry_sign  in  1  sign switch during entry
- entry_bcd  in  12  {huns,tens,ones} entry digits
- temp_bcd  in  12  {huns,tens,ones} current temperature
- temp_neg  in  1  temperature sign
- delta_bcd  in  12  {huns,tens,ones} subtractor output
- delta_neg  in  1  delta sign
- delta_valid  in  1  delta result meaningful
- seg_val  out  16  {d3,d2,d1,d0} digit codes to seven_seg
- seg_en  out  4  per-digit enable
- src  out  2  0=ENTRY, 1=TEMP, 2=DELTA, 3=BLANK
- frame_done  out  1  one-clk pulse when a rotation completes

Behaviour:
- All outputs registered; 1-clk latency from input change to output.
- Reset (rst=1 at a clk edge):
  - state=SHOW_TEMP, cnt=0, blink=1
  - seg_val={OFF,OFF,OFF,OFF}, seg_en=4'hF, src=1, frame_done=0
- Digit codes (shared constants): OFF=4'hF, NEG=4'hA; 0-9 pass through.
- States: ENTRY, SHOW_TEMP, BLANK_A, SHOW_DELTA, BLANK_B.
- cnt counts ticks within a state; it clears on every state change.
- Dwell expiry: tick=1 and cnt==N-1 (N=DWELL_TICKS or GAP_TICKS).
- Transitions, highest priority first:
  - entry_active=1 in any rotation state -> ENTRY next clk. Preempts even a same-cycle expiry.
  - ENTRY with entry_active=0 -> SHOW_TEMP, cnt=0, no frame_done.
  - SHOW_TEMP expiry -> BLANK_A.
  - BLANK_A expiry -> SHOW_DELTA if delta_valid, else SHOW_TEMP with frame_done.
  - SHOW_DELTA: delta_valid=0 -> BLANK_B immediately, without waiting for expiry. Otherwise expiry -> BLANK_B.
  - BLANK_B expiry -> SHOW_TEMP with frame_done.
- ENTRY output:
  - Digits 0..p (p=effective entry_pos) show entry_bcd; digits p+1..2 show OFF.
  - d3 = entry_sign ? NEG : OFF.
  - seg_en[p]=blink, other enables 1.
  - blink toggles on each tick while in ENTRY.
  - blink forced to 1 on entry into ENTRY and whenever entry_pos changes. The force wins over a same-cycle tick.
- SHOW_TEMP: d2..d0=temp_bcd, d3 = temp_neg ? NEG : OFF, seg_en=4'hF.
- SHOW_DELTA: same layout using delta_bcd and delta_neg.
- BLANK_A/B: all OFF, seg_en=4'hF, src=3.
- Data inputs are sampled every clk. Values changing mid-dwell appear on the next clk without restarting the dwell.
- frame_done is high for exactly one clk, coincident with the first SHOW_TEMP output cycle.
- tick arriving while rst=1 is ignored.

Decomposition:
- Shared constants package (existing constants include): OFF, NEG, src encodings, state encodings.
- One natural sub-module: disp_dwell_timer. It holds the tick counter with clear and a compare against a variable limit, and outputs expire.
- The state machine and output mux stay in disp_sched.

Test Plan:
1. Reset then idle, DWELL=2, GAP=1, temp=072, temp_neg=0, delta_valid=0 -> SHOW_TEMP shows 0x F072 for 2 ticks, blank 0xFFFF for 1 tick, back to temp with frame_done=1 for one clk.
2. delta_valid=1, delta=015, delta_neg=1 -> after first gap seg_val=0xA015 for 2 ticks, then BLANK_B 1 tick, then temp with frame_done.
3. entry_active=1 mid SHOW_DELTA, entry_pos=1, entry_bcd=0x034, entry_sign=1 -> next clk seg_val=0xAF34, src=0, seg_en[1] toggles 1->0->1 on successive ticks, other enables 1.
4. entry_pos 1->2 on the same clk as a tick -> blink stays 1. Release entry_active -> SHOW_TEMP with cnt=0 and no frame_done.
5. delta_valid drops during SHOW_DELTA cnt=0 -> BLANK_B on the next clk.
6. rst asserted during ENTRY -> next clk reset values, and the rotation restarts at SHOW_TEMP.
